// File: rtl/cordic_sincos_pipe.sv
// Fully pipelined CORDIC returning cos/sin over the full circle: quadrant fold at the
// input, STAGES micro-rotations, quadrant unfold at the output, valid/ready with a tag.
module cordic_sincos_pipe #(
  parameter int unsigned DATA_W  = 21,
  parameter int unsigned ANGLE_W = 16,
  parameter int unsigned STAGES  = 16,
  parameter int unsigned TAG_W   = 4
) (
  input  logic                     clock,
  input  logic                     aclr,
  input  logic                     clk_en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ANGLE_W-1:0]       in_angle,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_cos,
  output logic signed [DATA_W-1:0] out_sin,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int unsigned PROD_W = ANGLE_W + DATA_W + 2;
  localparam real PI    = 3.14159265358979323846;
  localparam real ONE_Q = 2.0 ** (DATA_W - 2);

  function automatic real atan_pow2(input int unsigned i);
    case (i)
      0:       return 0.7853981633974483;
      1:       return 0.4636476090008061;
      2:       return 0.24497866312686414;
      3:       return 0.12435499454676144;
      4:       return 0.06241880999595735;
      5:       return 0.031239833430268277;
      6:       return 0.015623728620476831;
      7:       return 0.007812341060101111;
      8:       return 0.0039062301319669718;
      9:       return 0.0019531225164788188;
      10:      return 0.0009765621895593195;
      11:      return 0.0004882812111948983;
      12:      return 0.00024414062014936177;
      13:      return 0.00012207031189367021;
      14:      return 0.00006103515617420877;
      15:      return 0.000030517578115526096;
      16:      return 0.000015258789061315762;
      17:      return 0.00000762939453110197;
      18:      return 0.000003814697265606496;
      19:      return 0.000001907348632810187;
      20:      return 0.0000009536743164059608;
      21:      return 0.00000047683715820308884;
      22:      return 0.00000023841857910155797;
      23:      return 0.00000011920928955078068;
      default: return 0.0;
    endcase
  endfunction

  function automatic logic [24*DATA_W-1:0] atan_table();
    logic [24*DATA_W-1:0] tab;
    tab = '0;
    for (int unsigned i = 0; i < 24; i++)
      tab[i*DATA_W +: DATA_W] = DATA_W'($rtoi(atan_pow2(i) * ONE_Q + 0.5));
    return tab;
  endfunction

  localparam logic [24*DATA_W-1:0]      ATAN_TAB = atan_table();
  localparam logic signed [DATA_W+1:0]  TWO_PI_Q = (DATA_W+2)'($rtoi(2.0 * PI * ONE_Q + 0.5));
  localparam logic signed [DATA_W-1:0]  X0       = DATA_W'($rtoi(0.6072529350 * ONE_Q + 0.5));

  logic                      w_adv;
  logic [1:0]                w_fold_q;
  logic signed [ANGLE_W-1:0] w_fold_r;
  logic signed [PROD_W-1:0]  w_prod;

  // Index 0 is the fold register; index k holds the result after micro-rotation k-1.
  logic                     r_v [STAGES+1];
  logic signed [DATA_W-1:0] r_x [STAGES+1];
  logic signed [DATA_W-1:0] r_y [STAGES+1];
  logic signed [DATA_W-1:0] r_z [STAGES];
  logic [1:0]               r_q [STAGES+1];
  logic [TAG_W-1:0]         r_t [STAGES+1];

  logic                     w_v [STAGES+1];
  logic signed [DATA_W-1:0] w_x [STAGES+1];
  logic signed [DATA_W-1:0] w_y [STAGES+1];
  logic signed [DATA_W-1:0] w_z [STAGES];
  logic [1:0]               w_q [STAGES+1];
  logic [TAG_W-1:0]         w_t [STAGES+1];

  logic                     r_out_valid;
  logic signed [DATA_W-1:0] r_cos;
  logic signed [DATA_W-1:0] r_sin;
  logic [TAG_W-1:0]         r_tag;
  logic signed [DATA_W-1:0] w_cos;
  logic signed [DATA_W-1:0] w_sin;

  assign w_adv    = clk_en && (!r_out_valid || out_ready);
  assign in_ready = w_adv;

  // Rounding the angle to the nearest quadrant leaves a residual within +-pi/4.
  always_comb begin
    w_fold_q = 2'((in_angle + ANGLE_W'(1 << (ANGLE_W - 3))) >> (ANGLE_W - 2));
    w_fold_r = $signed(in_angle - {w_fold_q, {(ANGLE_W-2){1'b0}}});
    w_prod   = PROD_W'(w_fold_r) * PROD_W'(TWO_PI_Q);
  end

  always_comb begin
    w_v = '{default: 1'b0};
    w_x = '{default: '0};
    w_y = '{default: '0};
    w_z = '{default: '0};
    w_q = '{default: '0};
    w_t = '{default: '0};
    w_v[0] = in_valid;
    w_x[0] = X0;
    w_y[0] = '0;
    w_z[0] = DATA_W'(w_prod >>> ANGLE_W);
    w_q[0] = w_fold_q;
    w_t[0] = in_tag;
    for (int unsigned k = 0; k < STAGES; k++) begin
      w_v[k+1] = r_v[k];
      w_q[k+1] = r_q[k];
      w_t[k+1] = r_t[k];
      if (!r_z[k][DATA_W-1]) begin
        w_x[k+1] = r_x[k] - (r_y[k] >>> k);
        w_y[k+1] = r_y[k] + (r_x[k] >>> k);
      end else begin
        w_x[k+1] = r_x[k] + (r_y[k] >>> k);
        w_y[k+1] = r_y[k] - (r_x[k] >>> k);
      end
    end
    // The residual angle after the final rotation is never consumed, so z stops one short.
    for (int unsigned k = 0; k + 1 < STAGES; k++) begin
      if (!r_z[k][DATA_W-1])
        w_z[k+1] = r_z[k] - $signed(ATAN_TAB[k*DATA_W +: DATA_W]);
      else
        w_z[k+1] = r_z[k] + $signed(ATAN_TAB[k*DATA_W +: DATA_W]);
    end
  end

  always_comb begin
    w_cos = r_x[STAGES];
    w_sin = r_y[STAGES];
    case (r_q[STAGES])
      2'd1: begin
        w_cos = -r_y[STAGES];
        w_sin = r_x[STAGES];
      end
      2'd2: begin
        w_cos = -r_x[STAGES];
        w_sin = -r_y[STAGES];
      end
      2'd3: begin
        w_cos = r_y[STAGES];
        w_sin = -r_x[STAGES];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int unsigned k = 0; k <= STAGES; k++) begin
        r_v[k] <= 1'b0;
        r_x[k] <= '0;
        r_y[k] <= '0;
        r_q[k] <= '0;
        r_t[k] <= '0;
      end
      for (int unsigned k = 0; k < STAGES; k++)
        r_z[k] <= '0;
      r_out_valid <= 1'b0;
      r_cos       <= '0;
      r_sin       <= '0;
      r_tag       <= '0;
    end else if (w_adv) begin
      for (int unsigned k = 0; k <= STAGES; k++) begin
        r_v[k] <= w_v[k];
        r_x[k] <= w_x[k];
        r_y[k] <= w_y[k];
        r_q[k] <= w_q[k];
        r_t[k] <= w_t[k];
      end
      for (int unsigned k = 0; k < STAGES; k++)
        r_z[k] <= w_z[k];
      r_out_valid <= r_v[STAGES];
      r_cos       <= w_cos;
      r_sin       <= w_sin;
      r_tag       <= r_t[STAGES];
    end
  end

  assign out_valid = r_out_valid;
  assign out_cos   = r_cos;
  assign out_sin   = r_sin;
  assign out_tag   = r_tag;

endmodule

// File: tb/tb_cordic_sincos_pipe.sv
// Scoreboard bench for cordic_sincos_pipe: accepted samples are queued with their angle,
// tag and accept cycle, and checked against a floating-point cos/sin model on each pop.
`timescale 1ns/1ps
module tb_cordic_sincos_pipe;

  localparam int unsigned DATA_W  = 21;
  localparam int unsigned ANGLE_W = 16;
  localparam int unsigned STAGES  = 16;
  localparam int unsigned TAG_W   = 4;
  localparam int          LAT     = STAGES + 2;
  localparam real         TOL     = 32.0;

  logic                     clock     = 1'b0;
  logic                     aclr      = 1'b1;
  logic                     clk_en    = 1'b0;
  logic                     in_valid  = 1'b0;
  logic                     out_ready = 1'b0;
  logic [ANGLE_W-1:0]       in_angle  = '0;
  logic [TAG_W-1:0]         in_tag    = '0;
  logic                     in_ready;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_cos;
  logic signed [DATA_W-1:0] out_sin;
  logic [TAG_W-1:0]         out_tag;

  typedef struct {
    logic [ANGLE_W-1:0] ang;
    logic [TAG_W-1:0]   tag;
    int unsigned        cyc;
  } item_t;

  item_t       sb_q[$];
  int unsigned cyc   = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  cordic_sincos_pipe #(
    .DATA_W (DATA_W),
    .ANGLE_W(ANGLE_W),
    .STAGES (STAGES),
    .TAG_W  (TAG_W)
  ) dut (
    .clock    (clock),
    .aclr     (aclr),
    .clk_en   (clk_en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_angle (in_angle),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_cos  (out_cos),
    .out_sin  (out_sin),
    .out_tag  (out_tag)
  );

  function automatic real model(input logic [ANGLE_W-1:0] a, input bit want_sin);
    real th;
    th = 6.283185307179586 * real'(a) / 65536.0;
    return (want_sin ? $sin(th) : $cos(th)) * 524288.0;
  endfunction

  function automatic real absr(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  // One clock of stimulus; reports whether a transfer and a pop happen on the coming edge.
  task automatic step(input logic v, input logic [ANGLE_W-1:0] a, input logic [TAG_W-1:0] t,
                      input logic ordy, input logic en, output logic acc, output logic pop);
    item_t it;
    @(negedge clock);
    in_valid  = v;
    in_angle  = a;
    in_tag    = t;
    out_ready = ordy;
    clk_en    = en;
    #1;
    acc = in_valid && in_ready;
    pop = out_valid && out_ready && clk_en;
    if (acc) begin
      it.ang = a;
      it.tag = t;
      it.cyc = cyc;
      sb_q.push_back(it);
    end
  endtask

  task automatic test_reset();
    aclr = 1'b1; clk_en = 1'b1; out_ready = 1'b0; in_valid = 1'b1; in_angle = 16'h1234;
    repeat (3) @(negedge clock);
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_vec++; if (out_cos !== '0) begin n_err++; $display("FAIL reset_cos got %0d want 0", out_cos); end
    n_vec++; if (out_sin !== '0) begin n_err++; $display("FAIL reset_sin got %0d want 0", out_sin); end
    n_vec++; if (out_tag !== '0) begin n_err++; $display("FAIL reset_tag got %0d want 0", out_tag); end
    @(negedge clock);
    aclr = 1'b0; in_valid = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    clk_en = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ready_clk_en_low got %b want 0", in_ready); end
    clk_en = 1'b1;
  endtask

  task automatic test_single();
    logic [ANGLE_W-1:0] angs [8];
    logic acc, pop, done;
    item_t it;
    int lat;
    angs = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h2000, 16'h1FFF, 16'h6000, 16'hE000};
    for (int unsigned i = 0; i < 8; i++) begin
      step(1'b1, angs[i], TAG_W'(i), 1'b1, 1'b1, acc, pop);
      n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL single_accept ang=%h got %b want 1", angs[i], acc); end
      done = 1'b0;
      for (int unsigned w = 0; w < 40 && !done; w++) begin
        step(1'b0, '0, '0, 1'b1, 1'b1, acc, pop);
        if (pop && sb_q.size() > 0) begin
          it = sb_q.pop_front();
          done = 1'b1;
          lat = int'(cyc) - int'(it.cyc);
          n_vec++; if (lat != LAT) begin n_err++; $display("FAIL single_latency ang=%h got %0d want %0d", it.ang, lat, LAT); end
          n_vec++; if (absr(real'(out_cos) - model(it.ang, 0)) > TOL) begin n_err++; $display("FAIL single_cos ang=%h got %0d want %0.1f+-32", it.ang, out_cos, model(it.ang, 0)); end
          n_vec++; if (absr(real'(out_sin) - model(it.ang, 1)) > TOL) begin n_err++; $display("FAIL single_sin ang=%h got %0d want %0.1f+-32", it.ang, out_sin, model(it.ang, 1)); end
          n_vec++; if (out_tag !== it.tag) begin n_err++; $display("FAIL single_tag ang=%h got %0d want %0d", it.ang, out_tag, it.tag); end
        end
      end
      if (!done) begin n_vec++; n_err++; $display("FAIL single_timeout ang=%h got no output want one", angs[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic acc, pop, stall;
    item_t it;
    int unsigned idx, got;
    idx = 0; got = 0;
    for (int unsigned t = 0; t < 300 && got < 40; t++) begin
      stall = (t >= 25 && t < 30);
      step(idx < 40, 16'(idx * 1601 + 77), TAG_W'(idx % 16), !stall, 1'b1, acc, pop);
      if (acc) idx++;
      if (stall) begin
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready t=%0d got %b want 0", t, in_ready); end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid t=%0d got %b want 1", t, out_valid); end
        if (sb_q.size() > 0) begin
          n_vec++; if (absr(real'(out_cos) - model(sb_q[0].ang, 0)) > TOL || out_tag !== sb_q[0].tag) begin
            n_err++; $display("FAIL bp_hold_data t=%0d got cos %0d tag %0d want %0.1f tag %0d", t, out_cos, out_tag, model(sb_q[0].ang, 0), sb_q[0].tag);
          end
        end
      end
      if (pop && sb_q.size() > 0) begin
        it = sb_q.pop_front();
        got++;
        n_vec++; if (absr(real'(out_cos) - model(it.ang, 0)) > TOL) begin n_err++; $display("FAIL bp_cos ang=%h got %0d want %0.1f+-32", it.ang, out_cos, model(it.ang, 0)); end
        n_vec++; if (absr(real'(out_sin) - model(it.ang, 1)) > TOL) begin n_err++; $display("FAIL bp_sin ang=%h got %0d want %0.1f+-32", it.ang, out_sin, model(it.ang, 1)); end
        n_vec++; if (out_tag !== it.tag) begin n_err++; $display("FAIL bp_tag ang=%h got %0d want %0d", it.ang, out_tag, it.tag); end
      end
    end
    n_vec++; if (got != 40 || sb_q.size() != 0) begin n_err++; $display("FAIL bp_count got %0d results want 40", got); end
  endtask

  task automatic test_clk_en();
    logic signed [DATA_W-1:0] ca [30];
    logic signed [DATA_W-1:0] sa [30];
    logic signed [DATA_W-1:0] snap_c, snap_s;
    logic snap_v, acc, pop, pause;
    item_t it;
    int unsigned idx, got;
    for (int unsigned run = 0; run < 2; run++) begin
      idx = 0; got = 0;
      snap_c = '0; snap_s = '0; snap_v = 1'b0;
      for (int unsigned t = 0; t < 200 && got < 30; t++) begin
        pause = (run == 1) && (t >= 22) && (t < 29);
        step(idx < 30, 16'(idx * 2311 + 5000), TAG_W'(idx + 3), 1'b1, !pause, acc, pop);
        if (acc) idx++;
        if (pause) begin
          n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ce_in_ready t=%0d got %b want 0", t, in_ready); end
          if (t == 22) begin
            snap_c = out_cos; snap_s = out_sin; snap_v = out_valid;
          end else begin
            n_vec++; if (out_cos !== snap_c || out_sin !== snap_s || out_valid !== snap_v) begin
              n_err++; $display("FAIL ce_hold t=%0d got %0d/%0d/%b want %0d/%0d/%b", t, out_cos, out_sin, out_valid, snap_c, snap_s, snap_v);
            end
          end
        end
        if (pop && sb_q.size() > 0) begin
          it = sb_q.pop_front();
          n_vec++; if (absr(real'(out_cos) - model(it.ang, 0)) > TOL || absr(real'(out_sin) - model(it.ang, 1)) > TOL) begin
            n_err++; $display("FAIL ce_model ang=%h got %0d/%0d want %0.1f/%0.1f", it.ang, out_cos, out_sin, model(it.ang, 0), model(it.ang, 1));
          end
          n_vec++; if (out_tag !== it.tag) begin n_err++; $display("FAIL ce_tag ang=%h got %0d want %0d", it.ang, out_tag, it.tag); end
          if (run == 0) begin
            ca[got] = out_cos; sa[got] = out_sin;
          end else begin
            n_vec++; if (out_cos !== ca[got] || out_sin !== sa[got]) begin
              n_err++; $display("FAIL ce_repeat idx=%0d got %0d/%0d want %0d/%0d", got, out_cos, out_sin, ca[got], sa[got]);
            end
          end
          got++;
        end
      end
      n_vec++; if (got != 30) begin n_err++; $display("FAIL ce_count run=%0d got %0d want 30", run, got); end
    end
  endtask

  task automatic test_random();
    logic acc, pop, pend;
    logic [ANGLE_W-1:0] a;
    logic [TAG_W-1:0] tg;
    item_t it;
    int unsigned sent, got;
    sent = 0; got = 0; pend = 1'b0; a = '0; tg = '0;
    for (int unsigned t = 0; t < 30000 && got < 1000; t++) begin
      if (!pend && sent < 1000 && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        a    = ANGLE_W'($urandom);
        tg   = TAG_W'($urandom);
      end
      step(pend, a, tg, 1'($urandom_range(0, 1)), 1'b1, acc, pop);
      if (acc) begin pend = 1'b0; sent++; end
      if (pop) begin
        if (sb_q.size() == 0) begin
          n_vec++; n_err++; $display("FAIL rnd_extra got unexpected output tag %0d want none", out_tag);
        end else begin
          it = sb_q.pop_front();
          got++;
          n_vec++; if (absr(real'(out_cos) - model(it.ang, 0)) > TOL) begin n_err++; $display("FAIL rnd_cos ang=%h got %0d want %0.1f+-32", it.ang, out_cos, model(it.ang, 0)); end
          n_vec++; if (absr(real'(out_sin) - model(it.ang, 1)) > TOL) begin n_err++; $display("FAIL rnd_sin ang=%h got %0d want %0.1f+-32", it.ang, out_sin, model(it.ang, 1)); end
          n_vec++; if (out_tag !== it.tag) begin n_err++; $display("FAIL rnd_tag ang=%h got %0d want %0d", it.ang, out_tag, it.tag); end
        end
      end
    end
    n_vec++; if (got != 1000 || sb_q.size() != 0) begin n_err++; $display("FAIL rnd_count got %0d results want 1000", got); end
  endtask

  task automatic test_reset_mid();
    logic acc, pop, done;
    item_t it;
    int lat;
    for (int unsigned t = 0; t < 28; t++) begin
      step(1'b1, 16'(t * 3001), TAG_W'(t), 1'b1, 1'b1, acc, pop);
      if (pop && sb_q.size() > 0) begin
        it = sb_q.pop_front();
        n_vec++; if (absr(real'(out_cos) - model(it.ang, 0)) > TOL || out_tag !== it.tag) begin
          n_err++; $display("FAIL rm_pre ang=%h got %0d tag %0d want %0.1f tag %0d", it.ang, out_cos, out_tag, model(it.ang, 0), it.tag);
        end
      end
    end
    @(negedge clock);
    aclr = 1'b1; in_valid = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid_clear got %b want 0", out_valid); end
    n_vec++; if (out_cos !== '0 || out_sin !== '0) begin n_err++; $display("FAIL rm_data_clear got %0d/%0d want 0/0", out_cos, out_sin); end
    sb_q.delete();
    @(negedge clock);
    aclr = 1'b0;
    step(1'b1, 16'h4000, 4'h9, 1'b1, 1'b1, acc, pop);
    n_vec++; if (acc !== 1'b1 || pop !== 1'b0) begin n_err++; $display("FAIL rm_accept got acc %b pop %b want 1 0", acc, pop); end
    done = 1'b0;
    for (int unsigned w = 0; w < 40 && !done; w++) begin
      step(1'b0, '0, '0, 1'b1, 1'b1, acc, pop);
      if (pop) begin
        done = 1'b1;
        if (sb_q.size() == 0) begin
          n_vec++; n_err++; $display("FAIL rm_stale got output tag %0d want none", out_tag);
        end else begin
          it = sb_q.pop_front();
          lat = int'(cyc) - int'(it.cyc);
          n_vec++; if (lat != LAT) begin n_err++; $display("FAIL rm_latency got %0d want %0d", lat, LAT); end
          n_vec++; if (absr(real'(out_sin) - 524288.0) > TOL) begin n_err++; $display("FAIL rm_sin got %0d want 524288+-32", out_sin); end
          n_vec++; if (absr(real'(out_cos)) > TOL) begin n_err++; $display("FAIL rm_cos got %0d want 0+-32", out_cos); end
          n_vec++; if (out_tag !== 4'h9) begin n_err++; $display("FAIL rm_tag got %0d want 9", out_tag); end
        end
      end
    end
    if (!done) begin n_vec++; n_err++; $display("FAIL rm_timeout got no output want one"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_clk_en();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
